// File: rtl/display_pkg.sv
// display_pkg: shared types and active-low seven-segment glyph constants for the display scan controller.
package display_pkg;

    typedef struct packed {
        logic       en;
        logic [3:0] val;
        logic       dp;
    } digit_t;

    typedef enum logic {SHOW, BLANK} scan_state_t;

    // Bit order is {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam digit_t DIGIT_RESET = '{en: 1'b0, val: 4'h0, dp: 1'b1};

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex value to active-low seven-segment pattern.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: eight-digit multiplexed seven-segment scan with blanking guard.
// Optional DISPLAY_SCAN_DIM_EN adds a 3-bit brightness input that shortens the lit part of each dwell.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [2:0] brightness,
`endif
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CW = $clog2(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t   state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    digit_t        dig, dig_n;
    digit_t        digits [8];
    logic          lit_n, start_n;
    logic [6:0]    seg_dec;

    assign digits[0] = d1;
    assign digits[1] = d2;
    assign digits[2] = d3;
    assign digits[3] = d4;
    assign digits[4] = d5;
    assign digits[5] = d6;
    assign digits[6] = d7;
    assign digits[7] = d8;

`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]  bright, bright_n;
    logic [31:0] on_limit;
    assign on_limit = ((32'(bright_n) + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
`endif

    // Outputs are computed from next-state values so they flip on the same edge as the FSM.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        dig_n   = dig;
        cnt_n   = cnt + 1'b1;
        start_n = 1'b0;
`ifdef DISPLAY_SCAN_DIM_EN
        bright_n = bright;
`endif
        if (state == BLANK && cnt == BLANK_LAST) begin
            state_n = SHOW;
            idx_n   = idx + 3'd1;
            dig_n   = digits[idx + 3'd1];
            cnt_n   = '0;
            start_n = idx == 3'd7;
`ifdef DISPLAY_SCAN_DIM_EN
            bright_n = brightness;
`endif
        end else if (state == SHOW && cnt == DWELL_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
        end
`ifdef DISPLAY_SCAN_DIM_EN
        lit_n = state_n == SHOW && dig_n.en && 32'(cnt_n) < on_limit;
`else
        lit_n = state_n == SHOW && dig_n.en;
`endif
    end

    seg7_decoder u_dec (
        .value(dig_n.val),
        .seg  (seg_dec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BLANK;
            idx         <= 3'd7;
            cnt         <= '0;
            dig         <= DIGIT_RESET;
            an          <= 8'hFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            dig         <= dig_n;
            an          <= lit_n ? ~(8'b1 << idx_n) : 8'hFF;
            seg         <= lit_n ? seg_dec : SEG_BLANK;
            dp          <= lit_n ? dig_n.dp : 1'b1;
            frame_start <= start_n;
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) bright <= 3'd7;
        else bright <= bright_n;
    end
`endif

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench driven by a frame-timeline model and a glyph table.
module tb_display_scan_controller;

`ifdef DISPLAY_SCAN_DIM_EN
    localparam int DW = 8;
`else
    localparam int DW = 4;
`endif
    localparam int BK = 2;
    localparam int SLOT = DW + BK;
    localparam int FRAME = 8 * SLOT;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } glyph_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] d [8];
    logic [2:0] brightness = 3'd7;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp, frame_start;

    exp_t   sbq [$];
    glyph_t glyphs [16];
    int     k;
    logic [5:0] lat_d;
    logic [2:0] lat_b;
    int     errors = 0;
    int     checks = 0;

    always #5 clock = ~clock;

    display_scan_controller #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BK)) dut (
        .clock      (clock),
        .reset      (reset),
        .d1         (d[0]),
        .d2         (d[1]),
        .d3         (d[2]),
        .d4         (d[3]),
        .d5         (d[4]),
        .d6         (d[5]),
        .d7         (d[6]),
        .d8         (d[7]),
`ifdef DISPLAY_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got an/seg/dp/fs=%h/%h/%b/%b want %h/%h/%b/%b", name, k,
                     got[16:9], got[8:2], got[1], got[0], want[16:9], want[8:2], want[1], want[0]);
        end
    endtask

    // Expected outputs after the next edge, from position in the frame timeline.
    task automatic push_expected();
        int m, slot, w, lim;
        exp_t e;
        k++;
        m = k - BK;
        e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        if (m >= 0) begin
            slot = (m / SLOT) % 8;
            w = m % SLOT;
            if (w == 0) begin
                lat_d = d[slot];
                lat_b = brightness;
            end
            lim = DW;
`ifdef DISPLAY_SCAN_DIM_EN
            lim = ((int'(lat_b) + 1) * DW) / 8;
`endif
            if (w < lim && lat_d[5]) begin
                e.an = ~(8'b1 << slot);
                e.seg = glyphs[lat_d[4:1]].seg;
                e.dp = lat_d[0];
            end
            e.fs = w == 0 && slot == 0;
        end
        sbq.push_back(e);
    endtask

    task automatic tick(input string name);
        exp_t e;
        push_expected();
        @(posedge clock);
        @(negedge clock);
        e = sbq.pop_front();
        chk(name, {an, seg, dp, frame_start}, {e.an, e.seg, e.dp, e.fs});
    endtask

    task automatic run(input string name, input int n);
        for (int i = 0; i < n; i++) tick(name);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_async", {an, seg, dp, frame_start}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        k = 0;
        lat_d = 6'b0_0000_1;
        lat_b = 3'd7;
        sbq.delete();
    endtask

    initial begin
        glyphs = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
                   '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
                   '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
                   '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};
        for (int i = 0; i < 8; i++) d[i] = {1'b1, 4'(i + 1), 1'b1};
        @(negedge clock);
        do_reset();
        run("scan_order", 2 * FRAME);
        run("pre_midreset", 4);
        do_reset();
        run("after_midreset", FRAME);
        d[2][5] = 1'b0;
        d[5][5] = 1'b0;
        run("disabled", 2 * FRAME);
        for (int i = 0; i < 8; i++) d[i] = {1'b1, 4'(i + 1), 1'b1};
        d[0] = {1'b1, 4'hA, 1'b0};
        d[1] = {1'b1, 4'hF, 1'b1};
        run("hex_dp", 2 * FRAME);
        for (int g = 0; g < 16; g++) begin
            d[0] = {1'b1, glyphs[g].val, g[0]};
            run("glyph", FRAME);
        end
        d[0] = {1'b1, 4'h1, 1'b1};
        do_reset();
        run("tear_pre", BK + 2);
        d[0] = {1'b1, 4'h2, 1'b1};
        tick("tear_hold_sb");
        chk("tear_hold", {an, seg, dp, frame_start}, {8'hFE, 7'h79, 1'b1, 1'b0});
        run("tear_mid", FRAME + BK - k);
        chk("tear_next", {an, seg, dp, frame_start}, {8'hFE, 7'h24, 1'b1, 1'b1});
        run("tear_post", FRAME);
`ifdef DISPLAY_SCAN_DIM_EN
        brightness = 3'd1;
        run("dim_b1", 2 * FRAME);
        brightness = 3'd7;
        run("dim_b7", 2 * FRAME);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexed scan scheduler for the eight-digit seven-segment display of the digital clock.
- Takes the eight 6-bit digit words produced by the watch datapath (d1..d8) and shares one segment bus between them.
- Drives one anode at a time, with a blanking guard between digits to suppress ghosting.
- Sits between the watch datapath and the board display pins.

Parameters:
- DWELL_CYCLES, 100000, clock cycles each digit is lit (1 ms at 100 MHz); must be >= 2.
- BLANK_CYCLES, 1000, clock cycles all anodes are off between digits; must be >= 1.

Ports:
- clock  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- d1..d8  in  6 each  digit word: bit5 = enable, bits4:1 = value (0-15), bit0 = dp, active-low (1 = dp off). d1 maps to an[0], d8 maps to an[7].
- an  out  8  anode selects, active-low.
- seg  out  7  segments, active-low; seg[0]=a through seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse on the first cycle of the digit-0 SHOW slot.

Behaviour:
- One clock. Reset is asynchronous and active-low: reset=0 forces the reset state immediately, regardless of clock.
- Reset state: an=8'hFF, seg=7'h7F, dp=1, frame_start=0, state=BLANK, idx=7, cnt=0, latched digit=6'b0_0000_1.
- Scan FSM has two states, SHOW and BLANK. cnt counts 0 up to the phase length minus 1.
  - BLANK, when cnt==BLANK_CYCLES-1: go to SHOW, idx <= idx+1 (wraps 7 to 0), latch d[idx+1], cnt <= 0.
  - SHOW, when cnt==DWELL_CYCLES-1: go to BLANK, cnt <= 0.
- Timing:
  - SHOW lasts exactly DWELL_CYCLES cycles; BLANK lasts exactly BLANK_CYCLES cycles.
  - Frame period = 8*(DWELL_CYCLES+BLANK_CYCLES).
  - First lit digit after reset release is idx 0, appearing BLANK_CYCLES cycles after release.
- Outputs are flop outputs, updated on the same edge as the state transition (no extra latency).
  - In SHOW with latched enable=1: an = ~(8'b1<<idx), seg = decode(latched value), dp = latched dp.
  - In SHOW with latched enable=0: an=8'hFF, seg=7'h7F, dp=1. Slot timing is unchanged.
  - In BLANK: an=8'hFF, seg=7'h7F, dp=1.
- Tear-free: the digit word is sampled only on the BLANK-to-SHOW edge. Input changes during a slot are not visible until that digit's next slot.
- Decode table: 0-9 decimal; 10-15 show A, b, C, d, E, F.
  - Examples: 1 gives 7'h79; 8 gives 7'h00; A gives 7'h08.
- Never more than one anode low at a time; an is never driven low during BLANK.
- Reset asserted mid-SHOW: outputs go to the reset state immediately. Scan restarts from BLANK with idx=7.
- cnt width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES)).

Optional Feature:
- Macro: DISPLAY_SCAN_DIM_EN.
- With the macro: an extra input port brightness [2:0] is present. It is latched together with the digit on the BLANK-to-SHOW edge.
  - During SHOW, the enabled anode is low only while cnt < ((brightness+1)*DWELL_CYCLES)/8. For the rest of the slot, an=8'hFF, seg=7'h7F, dp=1.
  - brightness=7 gives the full dwell.
- Without the macro: the brightness port is absent and the anode is lit for the whole dwell.

Decomposition:
- Package display_pkg:
  - digit_t, a packed struct {en, val[3:0], dp}.
  - scan_state_t enum {SHOW, BLANK}.
  - SEG_* localparam constants for the 16 glyphs.
  - SEG_BLANK = 7'h7F.
- Sub-module seg7_decoder: purely combinational, 4-bit value to 7-bit active-low segments. Instantiated once.

Test Plan:
(All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2 unless stated.)
- Reset: hold reset=0, then release. an=FF for 2 cycles, then an=FE for 4 cycles. Assert reset=0 mid-slot: an=FF, seg=7F, dp=1 in the same cycle, without waiting for a clock edge.
- Scan order: d1..d8 = enable 1, values 1..8, dp=1. an steps FE, FD, ... 7F, each for 4 cycles with 2 blank cycles between. seg shows 79 during the an=FE slot. frame_start pulses every 48 cycles, coincident with an going to FE.
- Disabled digits: d3 and d6 have enable=0. During the idx 2 and idx 5 slots an stays FF and seg=7F. Frame period is still 48 cycles.
- Hex and dp: d1 = {1, 4'hA, 0}. During slot 0, seg=08 and dp=0. d2 = {1, 4'hF, 1} gives seg=0E and dp=1.
- Tear-free: change d1 from value 1 to value 2 at cycle 2 of slot 0. seg stays 79 until the slot ends, then shows 24 in the next frame's slot 0.
- DIM (macro defined, DWELL_CYCLES=8): brightness=1 gives an=FE for 2 of 8 SHOW cycles. brightness=7 gives an=FE for all 8 cycles.
